ru_lsu: RTL
===========

Name: ru_lsu

Overview:
- Load/store unit sitting directly upstream of the data RAM in the single-cycle RISC-V core.
- Takes load/store requests from the execute stage and converts byte/halfword/word accesses into word-aligned RAM reads and writes, using read-modify-write for sub-word stores.
- Sign- or zero-extends load data.
- Holds the core with a stall signal until the access completes, honouring the RAM busy flag.

Parameters:
- MEM_WORDS, 32: number of 32-bit words in the attached RAM; byte addresses >= MEM_WORDS*4 fault.
- DATA_W, 32: data width; fixed at 32, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  load request from execute stage (level, held while stall=1)
- mem_write  in  1  store request from execute stage (level, held while stall=1)
- funct3  in  3  RISC-V funct3 of the load/store instruction
- addr  in  32  byte address
- store_data  in  32  rs2 value for stores
- load_data  out  32  extended load result, valid in DONE
- stall  out  1  high while the access is in progress; core holds PC and registers
- fault  out  1  one-cycle pulse in DONE for misaligned, out-of-range or illegal funct3
- ram_addr  out  32  word-aligned address to RAM ({addr_q[31:2],2'b00})
- ram_we  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM combinational read data
- ram_busy  in  1  RAM busy; no read capture or write while high

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; addr_q, funct3_q, sdata_q, word_q = 0.
  - load_data=0, ram_we=0, fault=0, stall=0, ram_wdata=0, ram_addr=0.
  - Mid-access reset drops ram_we immediately; no partial write is committed.
- States:
  - IDLE:
    - If mem_write or mem_read is asserted, latch addr/funct3/store_data.
    - Write has priority if both are asserted (treated as a store).
  - Transitions out of IDLE:
    - Illegal funct3 (load: 011,110,111; store: anything other than 000/001/010) -> DONE with fault.
    - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> DONE with fault.
    - addr >= MEM_WORDS*4 -> DONE with fault.
    - Load -> READ; SW -> WRITE; SB/SH -> READ.
  - READ: if ram_busy, stay. Otherwise capture ram_rdata into word_q, then go to DONE (load) or WRITE (sub-word store).
  - WRITE:
    - If ram_busy, stay with ram_we=0.
    - Otherwise ram_we=1 for exactly one cycle; ram_wdata = store_data (SW) or word_q with the selected byte/half lane replaced (SB/SH); then go to DONE.
  - DONE: stall=0; load_data valid for one cycle; fault pulses if the access faulted; go to IDLE next cycle.
- stall:
  - Combinational: (IDLE & (mem_read|mem_write)) | READ | WRITE.
  - Low in DONE, so the core advances on that edge.
  - A request still present in the cycle after DONE is a new instruction.
- Latency (no busy): load = 2 stall cycles; SW = 2; SB/SH = 3; fault = 1. Each ram_busy cycle adds one.
- Load extension:
  - Lane selected by addr_q[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - On fault, load_data = 0.
- ram_addr is driven from addr_q in READ/WRITE and from addr in IDLE.
- No RAM write ever occurs for a faulted store.

Decomposition:
- Package ru_pkg:
  - lsu_state_t enum {IDLE, READ, WRITE, DONE}.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- Sub-module ru_lsu_align (combinational):
  - Load lane extraction and extension.
  - Store lane merge.
  - Misalignment/illegal-funct3 detection.

Test Plan:
- Load byte: RAM word 1 = 0x8070_60F0. LB addr=0x4 -> load_data=0xFFFF_FFF0. LBU addr=0x7 -> 0x0000_0080. Stall high 2 cycles each.
- Store byte: SB addr=0x5, store_data=0x0000_00AB on word 0x8070_60F0 -> exactly one ram_we pulse with ram_wdata=0x8070_ABF0. Stall high 3 cycles.
- Word store with busy: SW addr=0x8, data=0xDEAD_BEEF, ram_busy high 2 cycles in WRITE -> ram_we stays 0 while busy, then one pulse. Total stall 4 cycles.
- Misaligned store: SH addr=0x3 -> fault pulse in DONE, no ram_we, stall high 1 cycle. LW addr=0x80 with MEM_WORDS=32 -> fault, load_data=0.
- Reset mid-op: assert rst during WRITE of an SB -> ram_we falls immediately, state IDLE, RAM word unchanged after reset release.
- Simultaneous mem_read=1 and mem_write=1 with SW addr=0xC -> treated as a store; one write of store_data; load_data=0.

Source files
------------

// File: rtl/ru_pkg.sv
// ru_pkg: shared types and constants for the ru_lsu load/store unit.
//   lsu_state_t : LSU sequencing states
//   F3_*        : RISC-V load/store funct3 encodings
package ru_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/ru_lsu_if.sv
// ru_lsu_if: bundles the execute-stage request/response signals and the data RAM port of the LSU.
//   slave  : LSU view (takes requests and RAM read data, drives response and RAM controls)
//   master : core + RAM view (drives requests and RAM read data/busy, observes the rest)
interface ru_lsu_if;

  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        fault;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_busy;

  modport slave (
    input  mem_read, mem_write, funct3, addr, store_data, ram_rdata, ram_busy,
    output load_data, stall, fault, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output mem_read, mem_write, funct3, addr, store_data, ram_rdata, ram_busy,
    input  load_data, stall, fault, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/ru_lsu_align.sv
// ru_lsu_align: combinational lane logic for the LSU.
//   i_chk_funct3/i_chk_addr_lo/i_chk_store : request being accepted, checked for legality
//   o_bad                                  : illegal funct3 or misaligned access
//   i_funct3/i_addr_lo                     : latched access descriptor
//   i_word                                 : RAM word captured in READ
//   i_sdata                                : latched store data
//   o_load                                 : lane-extracted, sign/zero-extended load value
//   o_merge                                : RAM write word (store lane merged into i_word)
module ru_lsu_align
  import ru_pkg::*;
(
  input  logic [2:0]  i_chk_funct3,
  input  logic [1:0]  i_chk_addr_lo,
  input  logic        i_chk_store,
  output logic        o_bad,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic        w_legal;
  logic        w_misaligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_legal = 1'b0;
    case (i_chk_funct3)
      F3_B, F3_H, F3_W: w_legal = 1'b1;
      F3_BU, F3_HU:     w_legal = ~i_chk_store;  // no unsigned stores
      default:          w_legal = 1'b0;
    endcase
    // funct3[1:0] encodes the access size for every legal encoding
    w_misaligned = 1'b0;
    case (i_chk_funct3[1:0])
      2'b01:   w_misaligned = i_chk_addr_lo[0];
      2'b10:   w_misaligned = (i_chk_addr_lo != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
    o_bad = ~w_legal | w_misaligned;
  end

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merge = i_sdata;
    case (i_funct3)
      F3_B: begin
        o_merge = i_word;
        case (i_addr_lo)
          2'd0: o_merge[7:0]   = i_sdata[7:0];
          2'd1: o_merge[15:8]  = i_sdata[7:0];
          2'd2: o_merge[23:16] = i_sdata[7:0];
          2'd3: o_merge[31:24] = i_sdata[7:0];
          default: o_merge[7:0] = i_sdata[7:0];
        endcase
      end
      F3_H: begin
        o_merge = i_word;
        if (i_addr_lo[1]) o_merge[31:16] = i_sdata[15:0];
        else              o_merge[15:0]  = i_sdata[15:0];
      end
      default: o_merge = i_sdata;
    endcase
  end

endmodule

// File: rtl/ru_lsu.sv
// ru_lsu: load/store unit in front of the data RAM of the single-cycle core.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ru_lsu_if.slave -- execute-stage request (mem_read/mem_write/funct3/addr/store_data),
//          response (load_data/stall/fault) and RAM port (ram_addr/ram_we/ram_wdata/
//          ram_rdata/ram_busy)
// Sub-word stores are done as read-modify-write; stall holds the core until DONE.
module ru_lsu
  import ru_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned DATA_W    = 32
) (
  input logic       clk,
  input logic       rst,
  ru_lsu_if.slave   bus
);

  localparam logic [32:0] LP_ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  lsu_state_t         r_state;
  lsu_state_t         w_state_d;
  logic [31:0]        r_addr;
  logic [2:0]         r_funct3;
  logic [DATA_W-1:0]  r_sdata;
  logic [DATA_W-1:0]  r_word;
  logic               r_store;
  logic               r_fault;

  logic               w_req;
  logic               w_bad;
  logic               w_oor;
  logic               w_fault;
  logic [31:0]        w_load;
  logic [31:0]        w_merge;

  assign w_req   = bus.mem_read | bus.mem_write;
  assign w_oor   = ({1'b0, bus.addr} >= LP_ADDR_LIMIT);
  assign w_fault = w_bad | w_oor;

  ru_lsu_align u_align (
    .i_chk_funct3  (bus.funct3),
    .i_chk_addr_lo (bus.addr[1:0]),
    .i_chk_store   (bus.mem_write),
    .o_bad         (w_bad),
    .i_funct3      (r_funct3),
    .i_addr_lo     (r_addr[1:0]),
    .i_word        (r_word),
    .i_sdata       (r_sdata),
    .o_load        (w_load),
    .o_merge       (w_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_fault)                                   w_state_d = DONE;
          else if (bus.mem_write && bus.funct3 == F3_W)  w_state_d = WRITE;
          else                                           w_state_d = READ;
        end
      end
      READ:    if (!bus.ram_busy) w_state_d = r_store ? WRITE : DONE;
      WRITE:   if (!bus.ram_busy) w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_sdata  <= '0;
      r_word   <= '0;
      r_store  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_addr   <= bus.addr;
        r_funct3 <= bus.funct3;
        r_sdata  <= bus.store_data;
        r_store  <= bus.mem_write;  // write wins when both are asserted
        r_fault  <= w_fault;
      end
      if (r_state == READ && !bus.ram_busy) r_word <= bus.ram_rdata;
    end
  end

  always_comb begin
    bus.stall     = ((r_state == IDLE) && w_req) || (r_state == READ) || (r_state == WRITE);
    bus.ram_we    = (r_state == WRITE) && !bus.ram_busy;
    bus.ram_wdata = (r_state == WRITE) ? w_merge : '0;
    bus.ram_addr  = (r_state == IDLE) ? {bus.addr[31:2], 2'b00} : {r_addr[31:2], 2'b00};
    bus.fault     = (r_state == DONE) && r_fault;
    bus.load_data = ((r_state == DONE) && !r_store && !r_fault) ? w_load : '0;
  end

endmodule
